// File: rtl/fp_pkg.sv
// Shared field constants and the exponentiation controller state type
// for arithmetic modulo p = 2^255 - 19.
package fp_pkg;

  localparam int unsigned FP_W           = 255;
  localparam logic [FP_W-1:0] FP_P         = {FP_W{1'b1}} - FP_W'(18);
  localparam logic [FP_W-1:0] FP_P_MINUS_2 = FP_P - FP_W'(2);
  localparam int unsigned FP_MUL_LATENCY = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SQR_ISSUE,
    ST_SQR_WAIT,
    ST_MUL_ISSUE,
    ST_MUL_WAIT,
    ST_FINISH
  } fp_pow_state_t;

endpackage

// File: rtl/fp_pow_exp_seq.sv
// Exponent bit walker: tracks the current exponent bit index, MSB-1 down to 0,
// and exposes that bit plus a flag for the final bit.
module fp_pow_exp_seq
  import fp_pkg::*;
#(
  parameter int unsigned          EXP_BITS = FP_W,
  parameter logic [EXP_BITS-1:0]  EXP      = EXP_BITS'(FP_P_MINUS_2)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic exp_bit_c,
  output logic last_c
);

  localparam int unsigned IW = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'((EXP_BITS > 1) ? EXP_BITS - 2 : 0);

  logic [IW-1:0] bit_idx;

  // Index never wraps: a decrement at zero is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (load) begin
      bit_idx <= IDX_TOP;
    end else if (dec && (bit_idx != '0)) begin
      bit_idx <= bit_idx - IW'(1);
    end
  end

  assign exp_bit_c = EXP[bit_idx];
  assign last_c    = (bit_idx == '0);

endmodule

// File: rtl/fp_pow_ctrl.sv
// MSB-first square-and-multiply controller driving an external fixed-latency
// field multiplier; with the default exponent p-2 it is the field inverter.
module fp_pow_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned          W           = FP_W,
  parameter int unsigned          EXP_BITS    = FP_W,
  parameter logic [EXP_BITS-1:0]  EXP         = EXP_BITS'(FP_P_MINUS_2),
  parameter int unsigned          MUL_LATENCY = FP_MUL_LATENCY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic [W-1:0] mul_d
);

  localparam int unsigned CW = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(MUL_LATENCY);

  fp_pow_state_t state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [W-1:0]  base_q, base_q_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          busy_nxt, done_nxt;
  logic [W-1:0]  result_nxt, mul_a_nxt, mul_b_nxt;
  logic          seq_load, seq_dec;
  logic          exp_bit_c, last_c;

  fp_pow_exp_seq #(
    .EXP_BITS (EXP_BITS),
    .EXP      (EXP)
  ) u_exp_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (seq_load),
    .dec       (seq_dec),
    .exp_bit_c (exp_bit_c),
    .last_c    (last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      acc      <= '0;
      base_q   <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      base_q   <= base_q_nxt;
      wait_cnt <= wait_cnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      result   <= result_nxt;
      mul_a    <= mul_a_nxt;
      mul_b    <= mul_b_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    base_q_nxt   = base_q;
    wait_cnt_nxt = wait_cnt;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    result_nxt   = result;
    mul_a_nxt    = mul_a;
    mul_b_nxt    = mul_b;
    seq_load     = 1'b0;
    seq_dec      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          base_q_nxt = base;
          acc_nxt    = base;
          seq_load   = 1'b1;
          busy_nxt   = 1'b1;
          state_nxt  = (EXP_BITS == 1) ? ST_FINISH : ST_SQR_ISSUE;
        end
      end
      ST_SQR_ISSUE: begin
        mul_a_nxt    = acc;
        mul_b_nxt    = acc;
        wait_cnt_nxt = CW'(1);
        state_nxt    = ST_SQR_WAIT;
      end
      ST_SQR_WAIT: begin
        if (wait_cnt == CNT_DONE) begin
          acc_nxt = mul_d;
          if (exp_bit_c) begin
            state_nxt = ST_MUL_ISSUE;
          end else if (last_c) begin
            state_nxt = ST_FINISH;
          end else begin
            seq_dec   = 1'b1;
            state_nxt = ST_SQR_ISSUE;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      ST_MUL_ISSUE: begin
        mul_a_nxt    = acc;
        mul_b_nxt    = base_q;
        wait_cnt_nxt = CW'(1);
        state_nxt    = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: begin
        if (wait_cnt == CNT_DONE) begin
          acc_nxt = mul_d;
          if (last_c) begin
            state_nxt = ST_FINISH;
          end else begin
            seq_dec   = 1'b1;
            state_nxt = ST_SQR_ISSUE;
          end
        end else begin
          wait_cnt_nxt = wait_cnt + CW'(1);
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // The done/result registers load on entry to FINISH, so done is high
    // exactly while FINISH is the current state.
    if (state_nxt == ST_FINISH) begin
      result_nxt = acc_nxt;
      done_nxt   = 1'b1;
      busy_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_pow_ctrl.sv
// Bench for fp_pow_ctrl: full 255-bit inverter plus two 8-bit (p=251) variants,
// each wired to a behavioural fixed-latency modular multiplier.
module tb_fp_pow_ctrl;
  import fp_pkg::*;

  localparam int          SP      = 251;
  localparam logic [7:0]  INV_EXP = 8'd249;
  localparam logic [3:0]  T2_EXP  = 4'b1011;
  localparam int          LIMIT   = 6000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_b, busy_b, done_b;
  logic [254:0] base_b, result_b, ma_b, mb_b, md_b;
  logic         start_s, busy_s, done_s;
  logic [7:0]   base_s, result_s, ma_s, mb_s, md_s;
  logic         start_t, busy_t, done_t;
  logic [7:0]   base_t, result_t, ma_t, mb_t, md_t;

  fp_pow_ctrl u_big (
    .clk(clk), .rst(rst), .start(start_b), .base(base_b), .busy(busy_b), .done(done_b),
    .result(result_b), .mul_a(ma_b), .mul_b(mb_b), .mul_d(md_b)
  );

  fp_pow_ctrl #(.W(8), .EXP_BITS(8), .EXP(INV_EXP), .MUL_LATENCY(3)) u_inv8 (
    .clk(clk), .rst(rst), .start(start_s), .base(base_s), .busy(busy_s), .done(done_s),
    .result(result_s), .mul_a(ma_s), .mul_b(mb_s), .mul_d(md_s)
  );

  fp_pow_ctrl #(.W(8), .EXP_BITS(4), .EXP(T2_EXP), .MUL_LATENCY(3)) u_t2 (
    .clk(clk), .rst(rst), .start(start_t), .base(base_t), .busy(busy_t), .done(done_t),
    .result(result_t), .mul_a(ma_t), .mul_b(mb_t), .mul_d(md_t)
  );

  function automatic logic [254:0] mm255(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] t;
    t = 510'(a) * 510'(b);
    return 255'(t % 510'(FP_P));
  endfunction

  function automatic logic [7:0] mm8(input logic [7:0] a, input logic [7:0] b);
    return 8'((int'(a) * int'(b)) % SP);
  endfunction

  // Multiplier models: operands registered by the controller count as the
  // first stage, so L-1 further stages give a product L edges after issue.
  logic [254:0] pipe_b [0:7];
  logic [7:0]   pipe_s [0:1];
  logic [7:0]   pipe_t [0:1];
  always @(posedge clk) begin
    pipe_b[0] <= mm255(ma_b, mb_b);
    for (int i = 1; i < 8; i++) pipe_b[i] <= pipe_b[i-1];
    pipe_s[0] <= mm8(ma_s, mb_s);
    pipe_s[1] <= pipe_s[0];
    pipe_t[0] <= mm8(ma_t, mb_t);
    pipe_t[1] <= pipe_t[0];
  end
  assign md_b = pipe_b[7];
  assign md_s = pipe_s[1];
  assign md_t = pipe_t[1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [254:0] act, input logic [254:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain repeated multiplication and the bit-count latency rule.
  function automatic int pow8(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % SP;
    return r;
  endfunction

  function automatic int ref_lat(input logic [254:0] e, input int nbits, input int lat_mul);
    int pc;
    pc = 0;
    for (int i = 0; i < nbits; i++) pc += int'(e[i]);
    return (nbits - 1 + pc - 1) * (lat_mul + 1) + 1;
  endfunction

  task automatic set_start(input int inst, input logic v, input logic [254:0] b);
    case (inst)
      0: begin start_b = v; base_b = b; end
      1: begin start_s = v; base_s = b[7:0]; end
      default: begin start_t = v; base_t = b[7:0]; end
    endcase
  endtask

  function automatic logic get_done(input int inst);
    return (inst == 0) ? done_b : (inst == 1) ? done_s : done_t;
  endfunction
  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy_b : (inst == 1) ? busy_s : busy_t;
  endfunction
  function automatic logic [254:0] get_res(input int inst);
    return (inst == 0) ? result_b : (inst == 1) ? 255'(result_s) : 255'(result_t);
  endfunction
  function automatic logic [254:0] get_ops(input int inst, input bit sel_b);
    if (inst == 0) return sel_b ? mb_b : ma_b;
    if (inst == 1) return sel_b ? 255'(mb_s) : 255'(ma_s);
    return sel_b ? 255'(mb_t) : 255'(ma_t);
  endfunction

  // Returns in the done cycle (or at the cycle limit); lat counts edges with
  // the start-accepting edge as 1. Operand changes are only legal at the
  // issue points 2 + k*(L+1).
  task automatic run_op(input int inst, input logic [254:0] b, input int glitch_at,
                        output logic [254:0] res, output int lat, output logic busy1,
                        output logic stable_ok);
    logic [254:0] pa, pb;
    int lm;
    lm = (inst == 0) ? 9 : 3;
    @(posedge clk); #1;
    set_start(inst, 1'b1, b);
    @(posedge clk); #1;
    set_start(inst, 1'b0, b);
    lat = 1;
    busy1 = get_busy(inst);
    pa = get_ops(inst, 1'b0);
    pb = get_ops(inst, 1'b1);
    stable_ok = 1'b1;
    while (!get_done(inst) && lat < LIMIT) begin
      if (lat == glitch_at) set_start(inst, 1'b1, ~b);
      else set_start(inst, 1'b0, b);
      @(posedge clk); #1;
      lat++;
      if ((get_ops(inst, 1'b0) != pa || get_ops(inst, 1'b1) != pb) && ((lat - 2) % (lm + 1) != 0))
        stable_ok = 1'b0;
      pa = get_ops(inst, 1'b0);
      pb = get_ops(inst, 1'b1);
    end
    set_start(inst, 1'b0, b);
    res = get_res(inst);
  endtask

  typedef struct {
    int           inst;
    logic [254:0] base;
    logic [254:0] res;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [254:0] res, rb, keep;
    logic         busy1, stable_ok;
    int           lat, lat_big, lat_s, lat_t, bad;

    lat_big = ref_lat(FP_P_MINUS_2, 255, 9);
    lat_s   = ref_lat(255'(INV_EXP), 8, 3);
    lat_t   = ref_lat(255'(T2_EXP), 4, 3);

    vecs[0] = '{0, 255'd2, (FP_P + 255'd1) >> 1, lat_big};
    vecs[1] = '{0, 255'd0, 255'd0, lat_big};
    vecs[2] = '{0, 255'd1, 255'd1, lat_big};
    vecs[3] = '{0, FP_P - 255'd1, FP_P - 255'd1, lat_big};
    vecs[4] = '{2, 255'd3, 255'(pow8(3, 11)), lat_t};
    vecs[5] = '{2, 255'd0, 255'(pow8(0, 11)), lat_t};
    vecs[6] = '{1, 255'd2, 255'(pow8(2, 249)), lat_s};
    vecs[7] = '{1, 255'd250, 255'(pow8(250, 249)), lat_s};

    rst = 1'b1;
    set_start(0, 1'b0, '0);
    set_start(1, 1'b0, '0);
    set_start(2, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 255'({busy_b, busy_s, busy_t}), 255'd0);
    chk("rst_done", 255'({done_b, done_s, done_t}), 255'd0);
    chk("rst_result_big", result_b, 255'd0);
    chk("rst_mul_big", ma_b | mb_b, 255'd0);
    chk("rst_small", 255'({result_s, ma_s, mb_s, result_t, ma_t, mb_t}), 255'd0);
    rst = 1'b0;

    // Table: inverse, small exponent, edge operands.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].inst, vecs[i].base, -1, res, lat, busy1, stable_ok);
      chk($sformatf("v%0d_done", i), 255'(get_done(vecs[i].inst)), 255'd1);
      chk($sformatf("v%0d_lat", i), 255'(lat), 255'(vecs[i].lat));
      chk($sformatf("v%0d_res", i), res, vecs[i].res);
      chk($sformatf("v%0d_busy", i), 255'(busy1), 255'd1);
      chk($sformatf("v%0d_stable", i), 255'(stable_ok), 255'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 255'(get_done(vecs[i].inst)), 255'd0);
    end

    // One random full-width inverse.
    rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (rb >= FP_P) rb = rb - FP_P;
    if (rb == '0) rb = 255'd1;
    run_op(0, rb, -1, res, lat, busy1, stable_ok);
    chk("big_rand_inv", mm255(res, rb), 255'd1);

    // Start pulses while busy and in the done cycle are ignored.
    run_op(1, 255'd5, 4, res, lat, busy1, stable_ok);
    chk("t4_res", res, 255'(pow8(5, 249)));
    chk("t4_lat", 255'(lat), 255'(lat_s));
    keep = res;
    set_start(1, 1'b1, 255'd9);
    @(posedge clk); #1;
    set_start(1, 1'b0, 255'd9);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy_s || done_s) bad++;
      @(posedge clk); #1;
    end
    chk("t4_no_restart", 255'(bad), 255'd0);
    chk("t4_res_held", 255'(result_s), keep);

    // Reset in the middle of the first squaring wait.
    @(posedge clk); #1;
    set_start(1, 1'b1, 255'd7);
    @(posedge clk); #1;
    set_start(1, 1'b0, 255'd7);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_busy", 255'(busy_s), 255'd0);
    chk("t5_done", 255'(done_s), 255'd0);
    chk("t5_result", 255'(result_s), 255'd0);
    chk("t5_mul", 255'({ma_s, mb_s}), 255'd0);
    @(posedge clk); #1;
    chk("t5_no_done", 255'(done_s), 255'd0);
    rst = 1'b0;
    run_op(1, 255'd7, -1, res, lat, busy1, stable_ok);
    chk("t5_res", res, 255'(pow8(7, 249)));
    chk("t5_lat", 255'(lat), 255'(lat_s));

    // Back-to-back random inverses.
    for (int i = 0; i < 100; i++) begin
      rb = 255'($urandom_range(1, SP - 1));
      run_op(1, rb, -1, res, lat, busy1, stable_ok);
      chk($sformatf("t6_%0d_inv", i), 255'((int'(res[7:0]) * int'(rb[7:0])) % SP), 255'd1);
      chk($sformatf("t6_%0d_stable", i), 255'(stable_ok), 255'd1);
      chk($sformatf("t6_%0d_lat", i), 255'(lat), 255'(lat_s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
